// File: rtl/match_count_pkg.sv
// Shared types and helpers for the sequential bit-match counter.
package match_count_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Compare mode encodings.
  localparam logic MODE_EQ   = 1'b0;  // count equal bits (XNOR)
  localparam logic MODE_DIFF = 1'b1;  // count differing bits (XOR)

  // Number of LANE-bit lanes needed to cover WIDTH bits.
  function automatic int lanes(input int width, input int lane);
    return (width + lane - 1) / lane;
  endfunction

endpackage

// File: rtl/match_count_seq_lane_popcount.sv
// lane_popcount: combinational ones-count of a LANE-bit vector, counting
// only the bit positions whose mask bit is set.
module lane_popcount
  import match_count_pkg::*;
#(
  parameter int LANE = 3
) (
  input  logic [LANE-1:0]            i_bits,
  input  logic [LANE-1:0]            i_mask,
  output logic [$clog2(LANE+1)-1:0]  o_count
);

  localparam int PC_W = $clog2(LANE + 1);

  // Sum the masked bits of the lane.
  always_comb begin
    // NOTE: assign a default before the loop so every path drives o_count
    // and no latch is inferred.
    o_count = '0;
    for (int j = 0; j < LANE; j++) begin
      o_count = o_count + PC_W'(i_bits[j] & i_mask[j]);
    end
  end

endmodule

// File: rtl/match_count_seq.sv
// match_count_seq: sequential bit-match / Hamming-distance counter.
// Compares two WIDTH-bit words LANE bits per clock, LSB lane first.
// Optional feature: define MATCH_COUNT_THRESH_EN to add the i_thresh input
// and the registered o_hit output (final count >= thresh).
module match_count_seq
  import match_count_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int LANE  = 3,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_count
`ifdef MATCH_COUNT_THRESH_EN
  ,
  input  logic [CNT_W-1:0]  i_thresh,
  output logic              o_hit
`endif
);

  localparam int NL     = lanes(WIDTH, LANE);
  localparam int LIDX_W = (NL > 1) ? $clog2(NL) : 1;
  localparam int PC_W   = $clog2(LANE + 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_mode;
  logic [LIDX_W-1:0]  r_lane_idx;
  logic [CNT_W-1:0]   r_acc;
`ifdef MATCH_COUNT_THRESH_EN
  logic [CNT_W-1:0]   r_thresh;
`endif

  logic [WIDTH-1:0]   w_cmp;
  logic [LANE-1:0]    w_lane_bits;
  logic [LANE-1:0]    w_lane_mask;
  logic [PC_W-1:0]    w_lane_cnt;
  logic [CNT_W-1:0]   w_sum;
  logic               w_last;

  // Per-bit compare, current lane selection and the running sum.
  always_comb begin
    w_cmp       = (r_mode == MODE_DIFF) ? (r_a ^ r_b) : ~(r_a ^ r_b);
    w_lane_bits = LANE'(w_cmp >> (int'(r_lane_idx) * LANE));
    // Positions past WIDTH in the final lane shift in as zero mask bits.
    w_lane_mask = LANE'({WIDTH{1'b1}} >> (int'(r_lane_idx) * LANE));
    w_sum       = r_acc + CNT_W'(w_lane_cnt);
    w_last      = (r_lane_idx == LIDX_W'(NL - 1));
  end

  lane_popcount #(
    .LANE (LANE)
  ) u_lane_popcount (
    .i_bits  (w_lane_bits),
    .i_mask  (w_lane_mask),
    .o_count (w_lane_cnt)
  );

  // Controller FSM with registered status outputs and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      // NOTE: operand registers are reset too; they are few bits and a known
      // value keeps the datapath free of X before the first request.
      r_a        <= '0;
      r_b        <= '0;
      r_mode     <= MODE_EQ;
      r_lane_idx <= '0;
      r_acc      <= '0;
      o_count    <= '0;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
      o_ready    <= 1'b1;
`ifdef MATCH_COUNT_THRESH_EN
      r_thresh   <= '0;
      o_hit      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, regardless of statement order.
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_a        <= i_a;
            r_b        <= i_b;
            r_mode     <= i_mode;
            r_lane_idx <= '0;
            r_acc      <= '0;
`ifdef MATCH_COUNT_THRESH_EN
            r_thresh   <= i_thresh;
`endif
            r_state    <= ST_RUN;
            o_ready    <= 1'b0;
            o_busy     <= 1'b1;
          end else begin
            r_state    <= ST_IDLE;
            o_ready    <= 1'b1;
            o_busy     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_last) begin
            o_count <= w_sum;
`ifdef MATCH_COUNT_THRESH_EN
            o_hit   <= (w_sum >= r_thresh);
`endif
            r_state <= ST_DONE;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
          end else begin
            r_acc      <= w_sum;
            r_lane_idx <= r_lane_idx + LIDX_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
